// File: rtl/fifo_byte_reader.sv
// Pops 128-bit words from an upstream FIFO and streams them out one byte at a time
// over a valid/ready handshake, counting every fully transmitted word.
module fifo_byte_reader #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         i_EN,
    input  logic         i_Buffer_Empty,
    input  logic [127:0] i_Data_Output,
    output logic         o_Data_Leaving,
    output logic [7:0]   o_Byte,
    output logic         o_Byte_Valid,
    input  logic         i_Byte_Ready,
    output logic         o_Busy,
    output logic [15:0]  o_Word_Count
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        CAPTURE,
        SEND
    } state_e;

    state_e        state_q, state_d;
    logic [127:0]  shift_q, shift_d;
    logic [3:0]    idx_q, idx_d;
    logic [15:0]   count_q, count_d;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values that were present before the clock edge.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        idx_d          = idx_q;
        count_d        = count_q;
        o_Data_Leaving = 1'b0;
        o_Byte_Valid   = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_EN && !i_Buffer_Empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                o_Data_Leaving = 1'b1;
                state_d        = CAPTURE;
            end
            CAPTURE: begin
                // FIFO read data is registered, so it is valid one cycle after the pop.
                shift_d = i_Data_Output;
                idx_d   = '0;
                state_d = SEND;
            end
            SEND: begin
                o_Byte_Valid = 1'b1;
                if (i_Byte_Ready) begin
                    shift_d = MSB_FIRST ? {shift_q[119:0], 8'h00} : {8'h00, shift_q[127:8]};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        count_d = count_q + 16'd1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The output end of the shift register is zero outside a word, so o_Byte idles at 0.
    assign o_Byte       = MSB_FIRST ? shift_q[127:120] : shift_q[7:0];
    assign o_Busy       = (state_q != IDLE);
    assign o_Word_Count = count_q;

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Runs MSB-first and LSB-first readers in lockstep from one FIFO model and checks
// every accepted byte, pop timing, stalls, reset behaviour and word counts.
module tb_fifo_byte_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         en;
    logic         empty;
    logic         ready;
    logic [127:0] rd_data;
    logic         leave_m, leave_l, valid_m, valid_l, busy_m, busy_l;
    logic [7:0]   byte_m, byte_l;
    logic [15:0]  cnt_m, cnt_l;

    fifo_byte_reader #(.MSB_FIRST(1'b1)) dut_msb (
        .i_Clk(clk), .i_Reset(rst), .i_EN(en), .i_Buffer_Empty(empty),
        .i_Data_Output(rd_data), .o_Data_Leaving(leave_m), .o_Byte(byte_m),
        .o_Byte_Valid(valid_m), .i_Byte_Ready(ready), .o_Busy(busy_m),
        .o_Word_Count(cnt_m)
    );

    fifo_byte_reader #(.MSB_FIRST(1'b0)) dut_lsb (
        .i_Clk(clk), .i_Reset(rst), .i_EN(en), .i_Buffer_Empty(empty),
        .i_Data_Output(rd_data), .o_Data_Leaving(leave_l), .o_Byte(byte_l),
        .o_Byte_Valid(valid_l), .i_Byte_Ready(ready), .o_Busy(busy_l),
        .o_Word_Count(cnt_l)
    );

    typedef struct {
        logic [127:0] word;
        logic [3:0]   pat;
        logic [15:0]  cnt;
    } vec_t;

    int           errors = 0;
    int           checks = 0;
    logic [127:0] fifo_q[$];
    logic [7:0]   exp_m[$];
    logic [7:0]   exp_l[$];
    int           pop_cyc[$];
    int           cyc = 0;
    int           accepted = 0;
    int           first_xfer = -1;
    int           last_xfer = -1;
    int           leave_pulses = 0;
    logic         prev_leave = 1'b0;
    logic         stalled = 1'b0;
    logic [7:0]   held_m, held_l;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [127:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < 16; i++) begin
            exp_m.push_back(w[127-8*i -: 8]);
            exp_l.push_back(w[8*i +: 8]);
        end
        empty = 1'b0;
    endtask

    // One clock: drive ready for the coming edge, service the FIFO model and score
    // whatever byte the DUTs will hand over on that edge.
    task automatic step(input logic rdy);
        @(posedge clk);
        #2;
        cyc++;
        ready = rdy;
        if (leave_m || leave_l) begin
            check("pop_lockstep", leave_l, leave_m);
            check("pop_single_cycle", prev_leave, 1'b0);
            check("pop_nonempty", fifo_q.size() != 0, 1'b1);
            leave_pulses++;
            if (fifo_q.size() != 0) begin
                rd_data = fifo_q.pop_front();
                pop_cyc.push_back(cyc);
            end
        end
        prev_leave = leave_m;
        empty = (fifo_q.size() == 0);
        if (stalled) begin
            check("stall_hold_msb", byte_m, held_m);
            check("stall_hold_lsb", byte_l, held_l);
            check("stall_valid", valid_m, 1'b1);
        end
        if (valid_m && rdy) begin
            check("valid_lockstep", valid_l, 1'b1);
            if (exp_m.size() == 0) begin
                check("unexpected_byte", valid_m, 1'b0);
            end else begin
                check("byte_msb", byte_m, exp_m.pop_front());
                check("byte_lsb", byte_l, exp_l.pop_front());
            end
            accepted++;
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
        end
        stalled = valid_m && !rdy;
        held_m  = byte_m;
        held_l  = byte_l;
    endtask

    task automatic drain(input logic [3:0] pat, input int budget, input string name);
        int  n = 0;
        bit  done = 1'b0;
        while (n < budget && !done) begin
            step(pat[n % 4]);
            n++;
            if (!busy_m && fifo_q.size() == 0 && exp_m.size() == 0) done = 1'b1;
        end
        check({name, "_completed"}, done, 1'b1);
    endtask

    task automatic new_word_stats();
        accepted   = 0;
        first_xfer = -1;
        last_xfer  = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[4];
        int   pulses0;
        int   n;

        vecs[0] = '{128'h000102030405060708090A0B0C0D0E0F, 4'b1111, 16'd1};
        vecs[1] = '{128'hDEADBEEF_0123_4567_89AB_CDEF_F00D_CAFE, 4'b1001, 16'd2};
        vecs[2] = '{128'hA5A5_5A5A_1234_8765_FEDC_BA98_7766_5544, 4'b0101, 16'd3};
        vecs[3] = '{128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100, 4'b0011, 16'd4};

        rst     = 1'b1;
        en      = 1'b0;
        empty   = 1'b1;
        ready   = 1'b0;
        rd_data = '0;
        #3;
        check("rst_valid", valid_m, 1'b0);
        check("rst_leave", leave_m, 1'b0);
        check("rst_busy", busy_m, 1'b0);
        check("rst_byte_msb", byte_m, 8'h00);
        check("rst_byte_lsb", byte_l, 8'h00);
        check("rst_count", cnt_m, 16'd0);
        #20;
        rst = 1'b0;
        en  = 1'b1;

        for (int v = 0; v < 4; v++) begin
            new_word_stats();
            pulses0 = leave_pulses;
            push_word(vecs[v].word);
            drain(vecs[v].pat, 200, "table_word");
            check("table_bytes", accepted, 16);
            check("table_pops", leave_pulses - pulses0, 1);
            check("table_count_msb", cnt_m, vecs[v].cnt);
            check("table_count_lsb", cnt_l, vecs[v].cnt);
            check("table_idle_valid", valid_m, 1'b0);
            if (vecs[v].pat == 4'b1111) check("table_consecutive", last_xfer - first_xfer, 15);
        end

        pulses0 = leave_pulses;
        for (int i = 0; i < 50; i++) begin
            step(1'b1);
            check("empty_busy", busy_m, 1'b0);
        end
        check("empty_no_pop", leave_pulses - pulses0, 0);

        pop_cyc.delete();
        push_word(128'h1111_2222_3333_4444_5555_6666_7777_8888);
        push_word(128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000);
        push_word(128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0);
        drain(4'b1111, 200, "three_words");
        check("three_pops", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check("three_spacing_1", pop_cyc[1] - pop_cyc[0], 19);
            check("three_spacing_2", pop_cyc[2] - pop_cyc[1], 19);
        end
        check("three_count", cnt_m, 16'd7);

        pop_cyc.delete();
        push_word(128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10);
        push_word(128'h1112_1314_1516_1718_191A_1B1C_1D1E_1F20);
        push_word(128'h2122_2324_2526_2728_292A_2B2C_2D2E_2F30);
        n = 0;
        while (pop_cyc.size() < 2 && n < 100) begin
            step(1'b1);
            n++;
        end
        check("en_drop_second_pop", pop_cyc.size(), 2);
        repeat (5) step(1'b1);
        en = 1'b0;
        repeat (60) step(1'b1);
        check("en_drop_count", cnt_m, 16'd9);
        check("en_drop_left_in_fifo", fifo_q.size(), 1);
        check("en_drop_busy", busy_m, 1'b0);
        en = 1'b1;
        drain(4'b1111, 100, "en_resume");
        check("en_resume_count", cnt_m, 16'd10);

        new_word_stats();
        push_word(128'hC0C1_C2C3_C4C5_C6C7_C8C9_CACB_CCCD_CECF);
        n = 0;
        while (accepted < 5 && n < 50) begin
            step(1'b1);
            n++;
        end
        check("midword_reached_5", accepted, 5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", valid_m, 1'b0);
        check("midrst_count", cnt_m, 16'd0);
        check("midrst_busy", busy_m, 1'b0);
        check("midrst_byte", byte_m, 8'h00);
        check("midrst_leave", leave_m, 1'b0);
        exp_m.delete();
        exp_l.delete();
        stalled    = 1'b0;
        prev_leave = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        new_word_stats();
        push_word(128'h000102030405060708090A0B0C0D0E0F);
        drain(4'b1111, 100, "after_reset");
        check("after_reset_bytes", accepted, 16);
        check("after_reset_consecutive", last_xfer - first_xfer, 15);
        check("after_reset_count", cnt_m, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_byte_reader.md
FIFO_BYTE_READER -- requirements
Module: fifo_byte_reader

Interface
REQ-001 Parameter MSB_FIRST, default 1; 1 = byte [127:120] sent first, 0 = byte [7:0] sent first.
REQ-002 i_Clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_Reset  input  1  asynchronous, active-high reset.
REQ-004 i_EN  input  1  enable; high permits starting a new FIFO pop.
REQ-005 i_Buffer_Empty  input  1  FIFO empty flag from the upstream 128-bit buffer.
REQ-006 i_Data_Output  input  128  FIFO registered read data, valid the cycle after a pop.
REQ-007 o_Data_Leaving  output  1  FIFO pop request, one-cycle pulse per word.
REQ-008 o_Byte  output  8  current output byte.
REQ-009 o_Byte_Valid  output  1  o_Byte holds a valid byte.
REQ-010 i_Byte_Ready  input  1  downstream accepts o_Byte when high with o_Byte_Valid.
REQ-011 o_Busy  output  1  high in any state other than IDLE.
REQ-012 o_Word_Count  output  16  count of fully transmitted 128-bit words, wraps modulo 65536.

Function
REQ-013 FSM states: IDLE, POP, CAPTURE, SEND; encoding is implementation choice.
REQ-014 IDLE -> POP when i_EN=1 and i_Buffer_Empty=0; otherwise remain in IDLE.
REQ-015 POP: o_Data_Leaving=1 for exactly that cycle; unconditional transition to CAPTURE.
REQ-016 o_Data_Leaving SHALL be 0 in every state except POP.
REQ-017 CAPTURE: load i_Data_Output into a 128-bit shift register and clear the 4-bit byte index; transition to SEND.
REQ-018 SEND: o_Byte_Valid=1; o_Byte = shift[127:120] if MSB_FIRST=1, else shift[7:0].
REQ-019 A transfer occurs on a rising edge with o_Byte_Valid=1 and i_Byte_Ready=1; shift register moves one byte toward the output end, index increments.
REQ-020 While i_Byte_Ready=0 in SEND, o_Byte and o_Byte_Valid SHALL hold unchanged.
REQ-021 On the 16th transfer (index 15), o_Word_Count increments by 1 and FSM returns to IDLE; o_Byte_Valid low in the following cycle.
REQ-022 o_Byte_Valid SHALL be 0 in IDLE, POP and CAPTURE.
REQ-023 i_EN is sampled only in IDLE; deasserting i_EN during POP/CAPTURE/SEND does not abort the word in progress.
REQ-024 i_Buffer_Empty is sampled only in IDLE; no pop is issued when empty, so FIFO underflow is impossible.
REQ-025 Minimum period per word with i_Byte_Ready tied high: 19 cycles (IDLE, POP, CAPTURE, 16 x SEND).
REQ-026 o_Word_Count wraps 0xFFFF -> 0x0000 without any flag.
REQ-027 o_Busy = 1 exactly when state is not IDLE.

Reset
REQ-028 While i_Reset=1, asynchronously: state=IDLE, o_Data_Leaving=0, o_Byte_Valid=0, o_Byte=0x00, shift register=0, index=0, o_Word_Count=0, o_Busy=0.
REQ-029 Reset asserted mid-word discards the partial word; o_Word_Count not incremented.
REQ-030 First pop after reset release no earlier than one cycle after i_Reset falls (IDLE evaluated at first edge).

Verification
REQ-031 Single word 0x000102...0F, MSB_FIRST=1, ready high -> one o_Data_Leaving pulse; bytes 0x00,0x01,...,0x0F on 16 consecutive cycles; o_Word_Count=1.
REQ-032 Same word, MSB_FIRST=0 -> bytes 0x0F,0x0E,...,0x00 in order.
REQ-033 i_Byte_Ready toggled 1,0,0,1 pattern during SEND -> o_Byte stable across stall cycles; no byte skipped or duplicated; 16 accepted bytes total.
REQ-034 i_Buffer_Empty=1 with i_EN=1 for 50 cycles -> o_Data_Leaving never asserted; o_Busy=0.
REQ-035 Assert i_Reset after 5th accepted byte -> o_Byte_Valid=0 immediately, o_Word_Count=0; next word after release sent complete from first byte.
REQ-036 Three words queued, ready high -> exactly three pops spaced 19 cycles apart; o_Word_Count=3; i_EN dropped during word 2 stops after word 2 (count 2).
